pgm_sched: RTL and testbench

- Replay scheduler for the packet-generator datapath.
- Sequences reads of one stored packet from the 144x128 packet RAM and emits it a programmed number of times toward the output engine.
- Emits it in 134-bit FAST data format, with a programmable inter-packet gap and almost-full back-pressure.
- Raises start/finish flags to the GAC side so PHV traffic is held while generation runs.

---
 rtl/pgm_sched.sv | 208 ++++++++++++++++++++
 tb/tb_pgm_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_sched.sv
// Replay scheduler: reads one stored packet from the packet RAM and emits it N times
// in FAST line format, honouring an inter-packet gap and downstream almost-full.
module pgm_sched #(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic [ADDR_W-1:0] cfg_pkt_lines,
   input  logic [CNT_W-1:0]  cfg_pkt_cnt,
   input  logic [CNT_W-1:0]  cfg_gap,
   output logic              ram_rd,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [143:0]      ram_rdata,
   output logic [133:0]      out_data,
   output logic              out_data_wr,
   output logic              out_valid_wr,
   output logic              out_valid,
   input  logic              in_alf,
   output logic              sent_start_flag,
   output logic              sent_finish_flag,
   output logic              busy,
   output logic [CNT_W-1:0]  sent_cnt,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_ALF = 3'd1,
      READ     = 3'd2,
      DRAIN    = 3'd3,
      GAP      = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] lines_last_q, lines_last_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              stop_pend_q, stop_pend_d;
   logic              start_flag_q, start_flag_d;
   logic              finish_flag_q, finish_flag_d;
   logic              out_wr_q, out_wr_d;
   logic [1:0]        hdr_q, hdr_d;

   logic              stop_seen;
   logic              rd_issue;
   logic [ADDR_W-1:0] rd_addr_c;
   logic [ADDR_W-1:0] lines_last_c;
   logic              unused_rdata;

   // Upper RAM bits carry nothing useful; the FAST header is rebuilt from line position.
   assign unused_rdata = ^ram_rdata[143:132];

   // Index of the last line: 0 encodes a full 128-line packet, 1 is widened to 2 lines.
   always_comb begin
      lines_last_c = cfg_pkt_lines - ADDR_W'(1);
      if (cfg_pkt_lines == '0) begin
         lines_last_c = '1;
      end else if (cfg_pkt_lines == ADDR_W'(1)) begin
         lines_last_c = ADDR_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      lines_last_d  = lines_last_q;
      pkt_cnt_d     = pkt_cnt_q;
      gap_d         = gap_q;
      gap_cnt_d     = gap_cnt_q;
      sent_cnt_d    = sent_cnt_q;
      rd_addr_d     = rd_addr_q;
      start_flag_d  = 1'b0;
      finish_flag_d = 1'b0;
      rd_issue      = 1'b0;
      rd_addr_c     = '0;
      stop_seen     = stop_pend_q | cfg_stop;

      case (state_q)
         IDLE: begin
            if (cfg_start && (cfg_pkt_cnt != '0)) begin
               state_d      = WAIT_ALF;
               lines_last_d = lines_last_c;
               pkt_cnt_d    = cfg_pkt_cnt;
               gap_d        = cfg_gap;
               sent_cnt_d   = '0;
               rd_addr_d    = '0;
               start_flag_d = 1'b1;
            end
         end
         WAIT_ALF: begin
            if (stop_seen) begin
               state_d       = IDLE;
               finish_flag_d = 1'b1;
            end else if (!in_alf) begin
               // Line 0 goes out in the deciding cycle so READ only covers lines 1..L-1.
               rd_issue  = 1'b1;
               rd_addr_c = '0;
               rd_addr_d = ADDR_W'(1);
               state_d   = READ;
            end
         end
         READ: begin
            rd_issue  = 1'b1;
            rd_addr_c = rd_addr_q;
            if (rd_addr_q == lines_last_q) begin
               state_d    = DRAIN;
               rd_addr_d  = '0;
               sent_cnt_d = sent_cnt_q + CNT_W'(1);
            end else begin
               rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if ((sent_cnt_q == pkt_cnt_q) || stop_seen) begin
               state_d       = IDLE;
               finish_flag_d = 1'b1;
            end else if (gap_q == '0) begin
               state_d = WAIT_ALF;
            end else begin
               state_d   = GAP;
               gap_cnt_d = gap_q;
            end
         end
         GAP: begin
            if (stop_seen) begin
               state_d       = IDLE;
               finish_flag_d = 1'b1;
            end else if (gap_cnt_q == CNT_W'(1)) begin
               state_d = WAIT_ALF;
            end else begin
               gap_cnt_d = gap_cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A stop requested in IDLE (including alongside cfg_start) is not remembered.
      if (state_d == IDLE) begin
         stop_pend_d = 1'b0;
      end else begin
         stop_pend_d = stop_pend_q | (cfg_stop && (state_q != IDLE));
      end

      out_wr_d = rd_issue;
      hdr_d    = hdr_q;
      if (rd_issue) begin
         if (rd_addr_c == '0) begin
            hdr_d = 2'b01;
         end else if (rd_addr_c == lines_last_q) begin
            hdr_d = 2'b10;
         end else begin
            hdr_d = 2'b11;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lines_last_q  <= '0;
         pkt_cnt_q     <= '0;
         gap_q         <= '0;
         gap_cnt_q     <= '0;
         sent_cnt_q    <= '0;
         rd_addr_q     <= '0;
         stop_pend_q   <= 1'b0;
         start_flag_q  <= 1'b0;
         finish_flag_q <= 1'b0;
         out_wr_q      <= 1'b0;
         hdr_q         <= 2'b00;
      end else begin
         state_q       <= state_d;
         lines_last_q  <= lines_last_d;
         pkt_cnt_q     <= pkt_cnt_d;
         gap_q         <= gap_d;
         gap_cnt_q     <= gap_cnt_d;
         sent_cnt_q    <= sent_cnt_d;
         rd_addr_q     <= rd_addr_d;
         stop_pend_q   <= stop_pend_d;
         start_flag_q  <= start_flag_d;
         finish_flag_q <= finish_flag_d;
         out_wr_q      <= out_wr_d;
         hdr_q         <= hdr_d;
      end
   end

   // Strobe semantics: ram_rd is a single-cycle read request with no back-pressure, the
   // RAM answers one cycle later, and out_data is only meaningful while out_data_wr=1.
   assign ram_rd           = rd_issue;
   assign ram_raddr        = rd_addr_c;
   assign out_data_wr      = out_wr_q;
   assign out_data         = out_wr_q ? {hdr_q, ram_rdata[131:0]} : '0;
   assign out_valid_wr     = (state_q == DRAIN);
   assign out_valid        = (state_q == DRAIN);
   assign sent_start_flag  = start_flag_q;
   assign sent_finish_flag = finish_flag_q;
   assign busy             = (state_q != IDLE);
   assign sent_cnt         = sent_cnt_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_pgm_sched.sv
// Directed bench for pgm_sched: RAM model, line monitor with expected queue,
// and one task per scenario.
module tb_pgm_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start, cfg_stop;
  logic [6:0]   cfg_pkt_lines;
  logic [15:0]  cfg_pkt_cnt, cfg_gap;
  logic         ram_rd;
  logic [6:0]   ram_raddr;
  logic [143:0] ram_rdata;
  logic [133:0] out_data;
  logic         out_data_wr, out_valid_wr, out_valid;
  logic         in_alf;
  logic         sent_start_flag, sent_finish_flag, busy;
  logic [15:0]  sent_cnt;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [143:0] mem [128];
  logic [133:0] exp_q [$];
  int head_cyc [$];
  int tail_cyc [$];
  int n_rd = 0, n_wr = 0, n_tail = 0, n_start = 0, n_finish = 0, data_bad = 0, cyc = 0;
  int last_addr = 0;
  int cur_last = 3;

  pgm_sched #(.ADDR_W(7), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_pkt_lines(cfg_pkt_lines), .cfg_pkt_cnt(cfg_pkt_cnt), .cfg_gap(cfg_gap),
    .ram_rd(ram_rd), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_valid_wr(out_valid_wr), .out_valid(out_valid),
    .in_alf(in_alf),
    .sent_start_flag(sent_start_flag), .sent_finish_flag(sent_finish_flag),
    .busy(busy), .sent_cnt(sent_cnt), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [143:0] data_of(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {10'h3FF, 2'b00, 100'h0, b, 24'hC0FFEE};
  endfunction

  function automatic logic [1:0] hdr_of(input int a);
    if (a == 0) return 2'b01;
    if (a == cur_last) return 2'b10;
    return 2'b11;
  endfunction

  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= mem[ram_raddr];
  end

  // scoreboard: every read predicts the line that must appear one cycle later
  always @(negedge clk) begin
    logic [133:0] e;
    logic [143:0] d;
    cyc++;
    if (!rst) begin
      if (out_data_wr) begin
        n_wr++;
        if (exp_q.size() == 0) data_bad++;
        else begin
          e = exp_q.pop_front();
          if (out_data !== e) data_bad++;
        end
        if (out_data[133:132] == 2'b01) head_cyc.push_back(cyc);
      end
      if (out_valid_wr) begin
        n_tail++;
        tail_cyc.push_back(cyc);
        if (!out_data_wr || !out_valid) data_bad++;
      end
      if (ram_rd) begin
        n_rd++;
        last_addr = int'(ram_raddr);
        d = data_of(int'(ram_raddr));
        exp_q.push_back({hdr_of(int'(ram_raddr)), d[131:0]});
      end
      if (sent_start_flag) n_start++;
      if (sent_finish_flag) n_finish++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int lines, input int cnt, input int gap);
    if (lines == 0) cur_last = 127;
    else if (lines == 1) cur_last = 1;
    else cur_last = lines - 1;
    cfg_pkt_lines = 7'(lines);
    cfg_pkt_cnt   = 16'(cnt);
    cfg_gap       = 16'(gap);
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sent_finish_flag) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd got=%0b exp=0", ram_rd); end
    checks++; if (out_data_wr !== 1'b0 || out_valid_wr !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_strobes got=%0b%0b%0b exp=000", out_data_wr, out_valid_wr, out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (busy !== 1'b0 || sent_start_flag !== 1'b0 || sent_finish_flag !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%0b%0b%0b exp=000", busy, sent_start_flag, sent_finish_flag); end
    checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL reset_sent_cnt got=%0d exp=0", sent_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int e_rd [1:6]   = '{1, 1, 1, 1, 0, 0};
    int e_wr [1:6]   = '{0, 1, 1, 1, 1, 0};
    int e_vwr [1:6]  = '{0, 0, 0, 0, 1, 0};
    int e_st [1:6]   = '{1, 0, 0, 0, 0, 0};
    int e_fin [1:6]  = '{0, 0, 0, 0, 0, 1};
    int e_busy [1:6] = '{1, 1, 1, 1, 1, 0};
    logic [1:0] e_hdr [1:6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [143:0] dl;
    logic [133:0] ed;
    int bad0 = data_bad;
    start_run(4, 1, 0);
    for (int c = 1; c <= 6; c++) begin
      checks++; if (int'(ram_rd) != e_rd[c]) begin errors++; $display("FAIL basic_ram_rd T+%0d got=%0b exp=%0d", c, ram_rd, e_rd[c]); end
      if (e_rd[c] == 1) begin
        checks++; if (int'(ram_raddr) != c - 1) begin errors++; $display("FAIL basic_raddr T+%0d got=%0d exp=%0d", c, ram_raddr, c - 1); end
      end
      checks++; if (int'(out_data_wr) != e_wr[c]) begin errors++; $display("FAIL basic_wr T+%0d got=%0b exp=%0d", c, out_data_wr, e_wr[c]); end
      if (e_wr[c] == 1) begin
        dl = data_of(c - 2);
        ed = {e_hdr[c], dl[131:0]};
        checks++; if (out_data !== ed) begin errors++; $display("FAIL basic_data T+%0d got=%h exp=%h", c, out_data, ed); end
      end
      checks++; if (int'(out_valid_wr) != e_vwr[c] || int'(out_valid) != e_vwr[c]) begin
        errors++; $display("FAIL basic_valid_wr T+%0d got=%0b/%0b exp=%0d", c, out_valid_wr, out_valid, e_vwr[c]); end
      checks++; if (int'(sent_start_flag) != e_st[c]) begin errors++; $display("FAIL basic_start T+%0d got=%0b exp=%0d", c, sent_start_flag, e_st[c]); end
      checks++; if (int'(sent_finish_flag) != e_fin[c]) begin errors++; $display("FAIL basic_finish T+%0d got=%0b exp=%0d", c, sent_finish_flag, e_fin[c]); end
      checks++; if (int'(busy) != e_busy[c]) begin errors++; $display("FAIL basic_busy T+%0d got=%0b exp=%0d", c, busy, e_busy[c]); end
      tick();
    end
    checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL basic_sent_cnt got=%0d exp=1", sent_cnt); end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL basic_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  task automatic test_gap();
    int s0 = n_start, f0 = n_finish, t0 = n_tail, h0 = head_cyc.size(), tc0 = tail_cyc.size(), bad0 = data_bad;
    bit ok;
    start_run(2, 3, 5);
    wait_finish(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_finish got=timeout exp=finish pulse"); end
    tick(); tick();
    checks++; if (n_tail - t0 != 3) begin errors++; $display("FAIL gap_tails got=%0d exp=3", n_tail - t0); end
    checks++; if (sent_cnt !== 16'd3) begin errors++; $display("FAIL gap_sent_cnt got=%0d exp=3", sent_cnt); end
    checks++; if (n_start - s0 != 1 || n_finish - f0 != 1) begin
      errors++; $display("FAIL gap_pulses got=%0d/%0d exp=1/1", n_start - s0, n_finish - f0); end
    for (int i = 0; i < 2; i++) begin
      if (head_cyc.size() >= h0 + i + 2 && tail_cyc.size() >= tc0 + i + 1) begin
        checks++; if (head_cyc[h0 + i + 1] - tail_cyc[tc0 + i] != 7) begin
          errors++; $display("FAIL gap_spacing pkt%0d got=%0d exp=7", i, head_cyc[h0 + i + 1] - tail_cyc[tc0 + i]); end
      end else begin
        checks++; errors++; $display("FAIL gap_heads got=%0d exp=3", head_cyc.size() - h0);
      end
    end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL gap_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  task automatic test_backpressure();
    int w0 = n_wr, t0 = n_tail, t1, bad0 = data_bad, rds = 0;
    bit ok;
    in_alf = 1'b1;
    start_run(4, 2, 0);
    for (int i = 0; i < 10; i++) begin
      if (ram_rd) rds++;
      tick();
    end
    checks++; if (rds != 0) begin errors++; $display("FAIL bp_held_reads got=%0d exp=0", rds); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got=%0b exp=1", busy); end
    in_alf = 1'b0;
    #1;
    checks++; if (ram_rd !== 1'b1 || ram_raddr !== 7'd0) begin
      errors++; $display("FAIL bp_release got=%0b/%0d exp=1/0", ram_rd, ram_raddr); end
    tick();
    in_alf = 1'b1;
    t1 = n_tail;
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      if (ram_rd) rds++;
      tick();
    end
    checks++; if (rds != 3) begin errors++; $display("FAIL bp_mid_packet_reads got=%0d exp=3", rds); end
    checks++; if (n_tail - t1 != 1) begin errors++; $display("FAIL bp_mid_packet_tail got=%0d exp=1", n_tail - t1); end
    in_alf = 1'b0;
    wait_finish(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_finish got=timeout exp=finish pulse"); end
    tick();
    checks++; if (n_wr - w0 != 8 || n_tail - t0 != 2) begin
      errors++; $display("FAIL bp_totals got=%0d lines/%0d tails exp=8/2", n_wr - w0, n_tail - t0); end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL bp_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  task automatic test_stop();
    int s0 = n_start, f0 = n_finish, t0 = n_tail, h0 = head_cyc.size(), bad0 = data_bad, hits = 0, rds = 0;
    bit ok;
    start_run(8, 100, 0);
    for (int i = 0; i < 200 && hits < 2; i++) begin
      if (ram_rd && ram_raddr == 7'd3) hits++;
      if (hits < 2) tick();
    end
    checks++; if (hits != 2) begin errors++; $display("FAIL stop_reach_line3 got=%0d exp=2", hits); end
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_finish(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_finish got=timeout exp=finish pulse"); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ram_rd) rds++;
    end
    checks++; if (sent_cnt !== 16'd2) begin errors++; $display("FAIL stop_sent_cnt got=%0d exp=2", sent_cnt); end
    checks++; if (n_tail - t0 != 2 || head_cyc.size() - h0 != 2) begin
      errors++; $display("FAIL stop_packets got=%0d tails/%0d heads exp=2/2", n_tail - t0, head_cyc.size() - h0); end
    checks++; if (n_start - s0 != 1 || n_finish - f0 != 1 || rds != 0) begin
      errors++; $display("FAIL stop_pulses got=%0d/%0d rd_after=%0d exp=1/1/0", n_start - s0, n_finish - f0, rds); end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL stop_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  task automatic test_bounds();
    int w0, t0, s0, r0, bad0 = data_bad;
    bit ok;
    w0 = n_wr; t0 = n_tail;
    start_run(0, 1, 0);
    wait_finish(300, ok);
    tick();
    checks++; if (!ok || n_wr - w0 != 128 || n_tail - t0 != 1) begin
      errors++; $display("FAIL bound_l0 got=%0d lines/%0d tails exp=128/1", n_wr - w0, n_tail - t0); end
    checks++; if (last_addr != 127) begin errors++; $display("FAIL bound_l0_last_addr got=%0d exp=127", last_addr); end
    w0 = n_wr; t0 = n_tail;
    start_run(1, 1, 0);
    wait_finish(30, ok);
    tick();
    checks++; if (!ok || n_wr - w0 != 2 || n_tail - t0 != 1 || last_addr != 1) begin
      errors++; $display("FAIL bound_l1 got=%0d lines/%0d tails/last %0d exp=2/1/1", n_wr - w0, n_tail - t0, last_addr); end
    s0 = n_start; r0 = n_rd;
    start_run(4, 0, 0);
    checks++; if (busy !== 1'b0 || sent_start_flag !== 1'b0) begin
      errors++; $display("FAIL bound_n0_accept got=%0b/%0b exp=0/0", busy, sent_start_flag); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (n_start != s0 || n_rd != r0) begin
      errors++; $display("FAIL bound_n0_activity got=%0d starts/%0d reads exp=0/0", n_start - s0, n_rd - r0); end
    s0 = n_start; w0 = n_wr; t0 = n_tail;
    start_run(4, 2, 3);
    tick(); tick(); tick();
    cfg_pkt_cnt = 16'd5;
    cfg_pkt_lines = 7'd9;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_finish(80, ok);
    tick();
    checks++; if (!ok || n_start - s0 != 1 || sent_cnt !== 16'd2) begin
      errors++; $display("FAIL bound_start_busy got=%0d starts/cnt %0d exp=1/2", n_start - s0, sent_cnt); end
    checks++; if (n_wr - w0 != 8 || n_tail - t0 != 2) begin
      errors++; $display("FAIL bound_cfg_latched got=%0d lines/%0d tails exp=8/2", n_wr - w0, n_tail - t0); end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL bound_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  task automatic test_reset_mid();
    int f0, t0, bad0, hit = 0;
    bit ok;
    start_run(8, 5, 0);
    for (int i = 0; i < 40 && hit == 0; i++) begin
      if (ram_rd && ram_raddr == 7'd4) hit = 1;
      else tick();
    end
    checks++; if (hit != 1) begin errors++; $display("FAIL rstmid_reach got=%0d exp=1", hit); end
    rst = 1'b1;
    tick();
    checks++; if (ram_rd !== 1'b0 || out_data_wr !== 1'b0 || out_valid_wr !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobes got=%0b%0b%0b%0b exp=0000", ram_rd, out_data_wr, out_valid_wr, out_valid); end
    checks++; if (out_data !== '0 || busy !== 1'b0 || sent_finish_flag !== 1'b0 || sent_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_state got=data %h busy %0b fin %0b cnt %0d exp=0", out_data, busy, sent_finish_flag, sent_cnt); end
    rst = 1'b0;
    exp_q.delete();
    f0 = n_finish;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (n_finish != f0) begin errors++; $display("FAIL rstmid_no_finish got=%0d exp=0", n_finish - f0); end
    t0 = n_tail; bad0 = data_bad;
    start_run(2, 1, 0);
    wait_finish(20, ok);
    tick();
    checks++; if (!ok || n_tail - t0 != 1 || sent_cnt !== 16'd1) begin
      errors++; $display("FAIL rstmid_rerun got=%0d tails/cnt %0d exp=1/1", n_tail - t0, sent_cnt); end
    checks++; if (data_bad != bad0) begin errors++; $display("FAIL rstmid_scoreboard got=%0d exp=0 bad lines", data_bad - bad0); end
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_pkt_lines = 7'd0;
    cfg_pkt_cnt = 16'd0;
    cfg_gap = 16'd0;
    in_alf = 1'b0;
    ram_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = data_of(i);
    test_reset();
    test_basic();
    tick(); tick();
    test_gap();
    tick(); tick();
    test_backpressure();
    tick(); tick();
    test_stop();
    tick(); tick();
    test_bounds();
    tick(); tick();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
